// File: rtl/address_counter.sv
// address_counter: 74161-style loadable address counter with a RUN/HALTED FSM and optional halt on terminal count
module address_counter #(
  parameter int WIDTH      = 8,
  parameter bit STOP_AT_TC = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_n,
  input  logic [WIDTH-1:0] d,
  input  logic             enable_p,
  input  logic             enable_t,
  input  logic             halt,
  input  logic             resume,
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             halted
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic inc, wrap;
  always_comb begin
    inc = state_q == RUN && enable_p && enable_t && !halt;
    wrap = inc && load_n && &cnt_q;
    cnt_d = !load_n ? d : inc ? cnt_q + WIDTH'(1) : cnt_q;
    state_d = halt ? HALTED :
              (state_q == HALTED && resume) ? RUN :
              (STOP_AT_TC && wrap) ? HALTED : state_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      state_q <= RUN;
    end else begin
      cnt_q <= cnt_d;
      state_q <= state_d;
    end
  assign q = cnt_q;
  assign rco = enable_t && &cnt_q;
  assign halted = state_q == HALTED;
endmodule

// File: tb/tb_address_counter.sv
// tb_address_counter: directed checks of the address counter, default build plus a stop-at-terminal-count build
module tb_address_counter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_n = 1'b1;
  logic [7:0] d = 8'h00;
  logic enable_p = 1'b0, enable_t = 1'b0, halt = 1'b0, resume = 1'b0;
  logic [7:0] q0, q1;
  logic rco0, rco1, halted0, halted1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  address_counter #(.WIDTH(8), .STOP_AT_TC(1'b0)) u0 (
    .clk(clk), .reset(reset), .load_n(load_n), .d(d), .enable_p(enable_p), .enable_t(enable_t),
    .halt(halt), .resume(resume), .q(q0), .rco(rco0), .halted(halted0));

  address_counter #(.WIDTH(8), .STOP_AT_TC(1'b1)) u1 (
    .clk(clk), .reset(reset), .load_n(load_n), .d(d), .enable_p(enable_p), .enable_t(enable_t),
    .halt(halt), .resume(resume), .q(q1), .rco(rco1), .halted(halted1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [7:0] eq, input logic eh);
    check({tag, "_q"}, q0, eq);
    check({tag, "_halted"}, halted0, eh);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 expect_state("rst_async", 8'h00, 1'b0);
    check("rst_rco", rco0, 1'b0);
    step();
    reset = 1'b0;
    enable_p = 1'b1;
    enable_t = 1'b1;
    step(); expect_state("cnt1", 8'h01, 1'b0);
    step(); expect_state("cnt2", 8'h02, 1'b0);
    step(); expect_state("cnt3", 8'h03, 1'b0);
    // load ignores enables; then walk through terminal count
    load_n = 1'b0; d = 8'hFE; enable_p = 1'b0; enable_t = 1'b0;
    step(); expect_state("load_fe", 8'hFE, 1'b0);
    load_n = 1'b1; enable_p = 1'b1; enable_t = 1'b1;
    #1 check("rco_fe", rco0, 1'b0);
    step(); expect_state("cnt_ff", 8'hFF, 1'b0);
    check("rco_ff", rco0, 1'b1);
    enable_t = 1'b0;
    #1 check("rco_t0", rco0, 1'b0);
    step(); check("hold_t0", q0, 8'hFF);
    enable_t = 1'b1;
    #1 check("rco_t1_p0", rco0, 1'b1);
    step(); expect_state("wrap00", 8'h00, 1'b0);
    check("rco_00", rco0, 1'b0);
    enable_p = 1'b0;
    step(); check("hold_p0", q0, 8'h00);
    enable_p = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("cnt5", q0, 8'h05);
    halt = 1'b1;
    step(); expect_state("halt_edge", 8'h05, 1'b1);
    halt = 1'b0;
    for (int i = 0; i < 4; i++) step();
    expect_state("halt_hold", 8'h05, 1'b1);
    resume = 1'b1;
    step(); expect_state("resume_edge", 8'h05, 1'b0);
    resume = 1'b0;
    step(); expect_state("resume_cnt", 8'h06, 1'b0);
    halt = 1'b1;
    step(); expect_state("halt2", 8'h06, 1'b1);
    resume = 1'b1;
    step(); expect_state("halt_wins", 8'h06, 1'b1);
    halt = 1'b0; load_n = 1'b0; d = 8'h40;
    step(); expect_state("load_resume", 8'h40, 1'b0);
    load_n = 1'b1; resume = 1'b0;
    step(); expect_state("cnt41", 8'h41, 1'b0);
    load_n = 1'b0; d = 8'h10; halt = 1'b1;
    step(); expect_state("load_halt", 8'h10, 1'b1);
    load_n = 1'b1; halt = 1'b0;
    step(); expect_state("halted_load_hold", 8'h10, 1'b1);
    load_n = 1'b0; d = 8'h33;
    step(); expect_state("halted_load", 8'h33, 1'b1);
    load_n = 1'b1; resume = 1'b1;
    step(); expect_state("resume33", 8'h33, 1'b0);
    resume = 1'b0;
    // asynchronous reset between edges, from RUN
    #2 reset = 1'b1;
    #1 expect_state("rst_mid_run", 8'h00, 1'b0);
    load_n = 1'b0; d = 8'hAA; halt = 1'b1;
    step(); expect_state("rst_held", 8'h00, 1'b0);
    load_n = 1'b1; halt = 1'b0;
    reset = 1'b0;
    step(); expect_state("after_rst", 8'h01, 1'b0);
    halt = 1'b1;
    step(); expect_state("halt_pre_rst", 8'h01, 1'b1);
    halt = 1'b0;
    #2 reset = 1'b1;
    #1 expect_state("rst_mid_halt", 8'h00, 1'b0);
    check("rst_u1_q", q1, 8'h00);
    check("rst_u1_halted", halted1, 1'b0);
    step();
    reset = 1'b0;
    step(); expect_state("after_rst2", 8'h01, 1'b0);
    // terminal-count behaviour in both builds
    load_n = 1'b0; d = 8'hFF;
    step();
    check("tc_load_q", q1, 8'hFF);
    check("tc_load_halted", halted1, 1'b0);
    load_n = 1'b1;
    step();
    check("tc_wrap_q", q1, 8'h00);
    check("tc_wrap_halted", halted1, 1'b1);
    expect_state("notc_wrap", 8'h00, 1'b0);
    step();
    check("tc_hold_q", q1, 8'h00);
    check("tc_hold_halted", halted1, 1'b1);
    expect_state("notc_cnt", 8'h01, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
